// File: rtl/portgroup_pkg.sv
// Shared types and constants for the port-group transmit core.
// Status word layout is consumed by the regf bus-read path.
package portgroup_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } tx_state_e;

  localparam int tx_depth_p = 2;
  localparam int lvl_w_c    = $clog2(tx_depth_p + 1);

  localparam int stat_busy_c    = 0;
  localparam int stat_lvl_lsb_c = 1;
  localparam int stat_ovf_c     = 3;
  localparam int stat_w_c       = 4;

endpackage

// File: rtl/portgroup_tx_fifo.sv
// Two-entry frame FIFO, head always in entry 0; exposes next-cycle head and
// level so the owner can register its outputs off them without extra latency.
module portgroup_tx_fifo
  import portgroup_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [2*width_p-1:0]   push_data,
  output logic                   full,
  output logic                   empty,
  output logic [lvl_w_c-1:0]     level_nxt,
  output logic [2*width_p-1:0]   head_nxt
);

  localparam int idx_w_c = (tx_depth_p > 1) ? $clog2(tx_depth_p) : 1;

  logic [2*width_p-1:0] mem_q [tx_depth_p];
  logic [2*width_p-1:0] mem_d [tx_depth_p];
  logic [lvl_w_c-1:0]   level_q;
  logic [idx_w_c-1:0]   wr_idx;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (level_q == lvl_w_c'(tx_depth_p));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop & ~empty;
  // A pop frees the tail slot in the same cycle, so a full FIFO still accepts.
  assign push_ok = push & (~full | pop_ok);
  assign wr_idx  = idx_w_c'(pop_ok ? (level_q - lvl_w_c'(1)) : level_q);

  always_comb begin
    mem_d     = mem_q;
    level_nxt = level_q;
    if (flush) begin
      level_nxt = '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < tx_depth_p - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
      end
      if (push_ok) begin
        mem_d[wr_idx] = push_data;
      end
      level_nxt = level_q + lvl_w_c'(push_ok) - lvl_w_c'(pop_ok);
    end
  end

  assign head_nxt = mem_d[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      level_q <= level_nxt;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/portgroup_tx.sv
// Transmit core: queues regf-written two-word frames and serializes each as
// two valid/ready beats. Every output, status included, comes straight from a flop.
module portgroup_tx
  import portgroup_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_i,
  input  logic                 regf_ctrl_ena_rval_i,
  input  logic [width_p-1:0]   regf_tx_data0_rval_i,
  input  logic                 regf_tx_data0_upd_i,
  input  logic [width_p-1:0]   regf_tx_data1_rval_i,
  output logic [stat_w_c-1:0]  regf_tx_stat_rbus_o,
  output logic                 tx_valid_o,
  output logic [width_p-1:0]   tx_data_o,
  output logic                 tx_last_o,
  input  logic                 tx_ready_i
);

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic                  ena;
  logic                  push_req;
  logic                  hs;
  logic                  pop;
  logic                  drop;
  logic                  ovf_q;
  logic                  ovf_d;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [lvl_w_c-1:0]    lvl_nxt;
  logic [2*width_p-1:0]  head_nxt;
  logic                  valid_d;
  logic                  last_d;
  logic [width_p-1:0]    data_d;
  logic [stat_w_c-1:0]   stat_d;

  assign ena      = regf_ctrl_ena_rval_i;
  assign push_req = regf_tx_data0_upd_i & ena;
  assign hs       = tx_valid_o & tx_ready_i;
  assign pop      = (state_q == BEAT1) & hs & ena;
  assign drop     = push_req & fifo_full & ~pop;
  // Dropping enable flushes the queue, so the sticky overflow goes with it.
  assign ovf_d    = ena & (ovf_q | drop);

  portgroup_tx_fifo #(
    .width_p (width_p)
  ) u_fifo (
    .clk       (main_clk_i),
    .rst       (main_rst_i),
    .push      (push_req),
    .pop       (pop),
    .flush     (~ena),
    .push_data ({regf_tx_data1_rval_i, regf_tx_data0_rval_i}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level_nxt (lvl_nxt),
    .head_nxt  (head_nxt)
  );

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q             <= IDLE;
      ovf_q               <= 1'b0;
      tx_valid_o          <= 1'b0;
      tx_last_o           <= 1'b0;
      tx_data_o           <= '0;
      regf_tx_stat_rbus_o <= '0;
    end else begin
      state_q             <= state_d;
      ovf_q               <= ovf_d;
      tx_valid_o          <= valid_d;
      tx_last_o           <= last_d;
      tx_data_o           <= data_d;
      regf_tx_stat_rbus_o <= stat_d;
    end
  end

  // Leaving IDLE on the push itself keeps first-beat latency at one cycle.
  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!fifo_empty || push_req) state_d = BEAT0;
        BEAT0:   if (hs) state_d = BEAT1;
        BEAT1:   if (hs) state_d = (lvl_nxt != '0) ? BEAT0 : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode the next state and next head so they can be registered.
  always_comb begin
    valid_d = 1'b0;
    last_d  = 1'b0;
    data_d  = '0;
    case (state_d)
      BEAT0: begin
        valid_d = 1'b1;
        data_d  = head_nxt[width_p-1:0];
      end
      BEAT1: begin
        valid_d = 1'b1;
        last_d  = 1'b1;
        data_d  = head_nxt[2*width_p-1:width_p];
      end
      default: ;
    endcase
    stat_d                               = '0;
    stat_d[stat_busy_c]                  = (state_d != IDLE);
    stat_d[stat_lvl_lsb_c +: lvl_w_c]    = lvl_nxt;
    stat_d[stat_ovf_c]                   = ovf_d;
  end

endmodule

// File: doc/portgroup_tx.md
# portgroup_tx

Transmit-side core of the port group: the counterpart that sources the data stream the receive core consumes. Bus software writes a two-word frame into regf fields; the block queues up to two frames and serializes each as two beats on a valid/ready stream. It returns busy, fill level and overflow status to the regf bus-read path. Sits between the generated regf and the port-group link, beside `portgroup_rx`.

## Interface
Parameters:
- `width_p`, 32, data word width (≥1)

Ports:
- `main_clk_i`  in  1  clock; single clock domain
- `main_rst_i`  in  1  reset, synchronous, active-high
- `regf_ctrl_ena_rval_i`  in  1  core read value; bus=RW core=RO in_regf=True
- `regf_tx_data0_rval_i`  in  width_p  core read value; bus=RW core=RO in_regf=True
- `regf_tx_data0_upd_i`  in  1  one-cycle bus-write strobe for tx_data0
- `regf_tx_data1_rval_i`  in  width_p  core read value; bus=RW core=RO in_regf=True
- `regf_tx_stat_rbus_o`  out  4  bus read value; bus=RO core=RW in_regf=False
- `tx_valid_o`  out  1  stream beat valid
- `tx_data_o`  out  width_p  stream beat data
- `tx_last_o`  out  1  marks second beat of frame
- `tx_ready_i`  in  1  downstream ready

## Operation
- Push: `regf_tx_data0_upd_i`=1 with enable=1 captures `{data1_rval, data0_rval}` of that cycle as one frame into a 2-entry frame FIFO. Software writes data1 first, then data0.
- Push while enable=0: ignored, no status change.
- Push while FIFO full and no pop this cycle: frame dropped, sticky `ovf`=1.
- A pop of the head frame happens on the handshake of its second beat. Push and pop in the same cycle when full: push accepted, level unchanged, no overflow.
- Output FSM:
  - IDLE -> BEAT0 when FIFO non-empty and enable=1.
  - BEAT0: `tx_data_o`=data0, `tx_last_o`=0. Goes to BEAT1 on `tx_valid_o & tx_ready_i`.
  - BEAT1: `tx_data_o`=data1, `tx_last_o`=1. On handshake, pops the frame, then goes to BEAT0 if another frame is queued, else IDLE.
- `tx_valid_o`=1 in BEAT0/BEAT1. Data and last stay stable until the handshake.
- Enable falling to 0, in any state:
  - FSM goes to IDLE next cycle.
  - FIFO is flushed (level 0) and `ovf` is cleared.
  - An in-flight frame is aborted. This is the only case where valid drops without a handshake; the downstream must treat it as an abort.
- Status bits: [0] busy (FSM≠IDLE), [2:1] level 0..2, [3] ovf.
- Reset: FSM IDLE, level 0, ovf 0; `tx_valid_o`, `tx_last_o`, `tx_data_o` and `regf_tx_stat_rbus_o` are all 0.

## Timing
- All outputs are registered, including status.
- Push in cycle N, FIFO empty and IDLE: level=1 visible at N+1, `tx_valid_o`=1 at N+1.
- Back-to-back frames with `tx_ready_i` held 1: one beat per cycle, no bubble between frames.
- Enable deasserted in cycle N: valid=0, level=0 and ovf=0 at N+1.
- Reset asserted mid-frame: all state returns to reset values at the next edge, overriding everything else.

## Structure
- Package `portgroup_pkg` holds:
  - FSM state enum `tx_state_e` (IDLE, BEAT0, BEAT1)
  - `tx_depth_p`=2
  - status bit-index constants (`stat_busy_c`, `stat_lvl_lsb_c`, `stat_ovf_c`)
- Sub-module `portgroup_tx_fifo`:
  - 2-entry, 2×width_p frame FIFO with push, pop, flush, full, empty and level.
  - Same-cycle push/pop is supported when full.

## Test plan
- Enable=1; data1=0xB, data0=0xA; strobe; ready=1 -> beats 0xA (last=0), 0xB (last=1) at cycles N+1 and N+2; status returns to 0.
- ready=0; push 3 frames -> level=2, ovf=1, third frame never transmitted; status=0b1101 (ovf=1, level=2, busy=1).
- Full FIFO; push coincides with second-beat handshake -> level stays 2, ovf=0, pushed frame transmitted later.
- Disable during BEAT1 with one frame queued -> valid=0, status=0 next cycle; re-enable -> no beats emitted.
- Reset asserted with valid high and ready=0 -> all outputs 0 at next edge; a strobe with enable=0 -> no change.
